// File: rtl/apu_cmd_sched.sv
// APU command scheduler: queues CPU writes aimed at the VDC sub-CPU (APU)
// and presents them one at a time on APU port A under an ACK handshake.
// Build option: define APU_CMD_FIFO_EN for the queued FIFO + handshake FSM.
// Without it, each selected CPU write is latched straight onto APU_DB.
module apu_cmd_sched #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CP2_NEGEDGE,
  input  logic       SCPUB,
  input  logic       WRB,
  input  logic [7:0] DB_I,
  input  logic       APU_RESB,
  input  logic       APU_ACK,
  output logic [7:0] APU_DB,
  output logic       CPU_INT,
  output logic       FULL,
  output logic       EMPTY,
  output logic       OVF
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("apu_cmd_sched: DEPTH must be a power of two in 2..16");
  end

  // CPU write aimed at the APU, sampled on the phase-2 falling edge.
  logic wr_hit;
  assign wr_hit = CP2_NEGEDGE & ~SCPUB & ~WRB;

`ifdef APU_CMD_FIFO_EN

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RETIRE  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    db_q;
  logic          wr_armed, ack_prev, ovf_q;
  logic          wr_event, push, pop, load_db, ack_rise, full, empty;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wr_event = wr_hit & wr_armed & APU_RESB;
  assign push     = wr_event & ~full;
  assign ack_rise = APU_ACK & ~ack_prev;

  // Arm once per CPU write cycle: a selected write disarms, any other strobe re-arms.
  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (RESET) begin
      wr_armed <= 1'b1;
    end else if (CP2_NEGEDGE) begin
      wr_armed <= ~wr_hit;
    end
  end

  // Previous ACK level for rising-edge detection.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ack_prev <= 1'b0;
    end else begin
      ack_prev <= APU_ACK;
    end
  end

  // Handshake FSM: present the head, pop on ACK rise, wait for ACK release.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
    state_next = state;
    pop        = 1'b0;
    load_db    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = PRESENT;
          load_db    = 1'b1;
        end
      end
      PRESENT: begin
        if (ack_rise) begin
          state_next = RETIRE;
          pop        = 1'b1;
        end
      end
      RETIRE: begin
        if (!APU_ACK) begin
          if (!empty) begin
            state_next = PRESENT;
            load_db    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Queue bookkeeping, overflow flag, FSM state and the presented byte.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      db_q   <= 8'h00;
    end else if (!APU_RESB) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      db_q   <= 8'h00;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_event && full) ovf_q <= 1'b1;
      if (load_db) db_q <= mem[rd_ptr];
    end
  end

  // Storage array written at the tail.
  always_ff @(posedge CLK) begin
    // NOTE: the array has no reset; entries are only read once count says they were written.
    if (push) mem[wr_ptr] <= DB_I;
  end

  assign APU_DB  = db_q;
  assign FULL    = full;
  assign EMPTY   = empty;
  assign OVF     = ovf_q;
  assign CPU_INT = APU_ACK & empty;

`else

  logic [7:0] db_q;

  // Direct path: every selected write lands on APU port A one clock later.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      db_q <= 8'h00;
    end else if (!APU_RESB) begin
      db_q <= 8'h00;
    end else if (wr_hit) begin
      db_q <= DB_I;
    end
  end

  assign APU_DB  = db_q;
  assign FULL    = 1'b0;
  assign EMPTY   = 1'b1;
  assign OVF     = 1'b0;
  assign CPU_INT = APU_ACK;

`endif

endmodule

// File: tb/tb_apu_cmd_sched.sv
// Directed testbench for apu_cmd_sched; covers the build selected by APU_CMD_FIFO_EN.
module tb_apu_cmd_sched;

  logic       clk = 1'b0;
  logic       rst, cp2_negedge, scpub, wrb, apu_resb, apu_ack;
  logic [7:0] db_i, apu_db;
  logic       cpu_int, full, empty, ovf;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  apu_cmd_sched #(.DEPTH(4)) dut (
    .CLK(clk), .RESET(rst), .CP2_NEGEDGE(cp2_negedge), .SCPUB(scpub), .WRB(wrb),
    .DB_I(db_i), .APU_RESB(apu_resb), .APU_ACK(apu_ack), .APU_DB(apu_db),
    .CPU_INT(cpu_int), .FULL(full), .EMPTY(empty), .OVF(ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CP2 strobe followed by one quiet clock.
  task automatic strobe(input logic sel_n, input logic wr_n, input logic [7:0] d);
    scpub = sel_n; wrb = wr_n; db_i = d; cp2_negedge = 1'b1;
    tick();
    cp2_negedge = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; cp2_negedge = 1'b0; scpub = 1'b1; wrb = 1'b1; db_i = 8'h00;
    apu_resb = 1'b1; apu_ack = 1'b0;
    #2;
    if (apu_db !== 8'h00) begin errors++; $display("FAIL reset_apu_db: got %h expected 00", apu_db); end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++;
    if (cpu_int !== 1'b0) begin errors++; $display("FAIL reset_cpu_int: got %b expected 0", cpu_int); end
    checks++;
    tick();
    rst = 1'b0;
    tick();
  endtask

`ifdef APU_CMD_FIFO_EN

  task automatic write_cycle(input logic [7:0] d);
    strobe(1'b0, 1'b0, d);
    strobe(1'b1, 1'b1, d);
  endtask

  task automatic ack_pulse(output logic int_seen, output logic empty_seen);
    apu_ack = 1'b1;
    tick();
    int_seen = cpu_int; empty_seen = empty;
    apu_ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_single_write();
    logic i_s, e_s;
    scpub = 1'b0; wrb = 1'b0; db_i = 8'h5A; cp2_negedge = 1'b1;
    tick();
    if (apu_db !== 8'h00) begin errors++; $display("FAIL single_early_db: got %h expected 00", apu_db); end
    checks++;
    if (empty !== 1'b0) begin errors++; $display("FAIL single_empty: got %b expected 0", empty); end
    checks++;
    cp2_negedge = 1'b0; scpub = 1'b1; wrb = 1'b1;
    tick();
    if (apu_db !== 8'h5A) begin errors++; $display("FAIL single_db_2clk: got %h expected 5a", apu_db); end
    checks++;
    if (cpu_int !== 1'b0) begin errors++; $display("FAIL single_cpu_int: got %b expected 0", cpu_int); end
    checks++;
    strobe(1'b1, 1'b1, 8'h00);
    ack_pulse(i_s, e_s);
    if (i_s !== 1'b1) begin errors++; $display("FAIL single_ack_int: got %b expected 1", i_s); end
    checks++;
    if (apu_db !== 8'h5A) begin errors++; $display("FAIL single_db_hold: got %h expected 5a", apu_db); end
    checks++;
  endtask

  task automatic test_wrb_held();
    logic i_s, e_s;
    strobe(1'b0, 1'b0, 8'h11);
    strobe(1'b0, 1'b0, 8'h11);
    strobe(1'b0, 1'b0, 8'h11);
    strobe(1'b1, 1'b1, 8'h00);
    if (apu_db !== 8'h11) begin errors++; $display("FAIL held_db: got %h expected 11", apu_db); end
    checks++;
    ack_pulse(i_s, e_s);
    if (e_s !== 1'b1) begin errors++; $display("FAIL held_one_entry: empty got %b expected 1", e_s); end
    checks++;
    tick();
    if (empty !== 1'b1) begin errors++; $display("FAIL held_stay_empty: got %b expected 1", empty); end
    checks++;
  endtask

  task automatic test_overflow();
    logic i_s, e_s;
    for (int k = 1; k <= 4; k++) write_cycle(8'(k));
    if (full !== 1'b1) begin errors++; $display("FAIL ovf_full4: got %b expected 1", full); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", ovf); end
    checks++;
    write_cycle(8'h05);
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    checks++;
    if (apu_db !== 8'h01) begin errors++; $display("FAIL ovf_head: got %h expected 01", apu_db); end
    checks++;
    for (int k = 1; k <= 4; k++) begin
      ack_pulse(i_s, e_s);
      if (i_s !== (k == 4)) begin errors++; $display("FAIL ovf_int_%0d: got %b expected %b", k, i_s, (k == 4)); end
      checks++;
      if (k < 4 && apu_db !== 8'(k + 1)) begin errors++; $display("FAIL ovf_order_%0d: got %h expected %h", k, apu_db, 8'(k + 1)); end
      if (k < 4) checks++;
    end
    if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL ovf_drained: got empty=%b full=%b expected 1/0", empty, full); end
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    checks++;
  endtask

  task automatic test_push_pop();
    logic i_s, e_s;
    write_cycle(8'h21);
    write_cycle(8'h22);
    apu_ack = 1'b1; scpub = 1'b0; wrb = 1'b0; db_i = 8'h23; cp2_negedge = 1'b1;
    tick();
    if (full !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL pp_flags: got full=%b empty=%b expected 0/0", full, empty); end
    checks++;
    if (cpu_int !== 1'b0) begin errors++; $display("FAIL pp_int: got %b expected 0", cpu_int); end
    checks++;
    cp2_negedge = 1'b0; apu_ack = 1'b0; scpub = 1'b1; wrb = 1'b1;
    tick();
    if (apu_db !== 8'h22) begin errors++; $display("FAIL pp_next: got %h expected 22", apu_db); end
    checks++;
    strobe(1'b1, 1'b1, 8'h00);
    ack_pulse(i_s, e_s);
    if (i_s !== 1'b0 || e_s !== 1'b0) begin errors++; $display("FAIL pp_ack2: got int=%b empty=%b expected 0/0", i_s, e_s); end
    checks++;
    if (apu_db !== 8'h23) begin errors++; $display("FAIL pp_tail: got %h expected 23", apu_db); end
    checks++;
    ack_pulse(i_s, e_s);
    if (i_s !== 1'b1 || e_s !== 1'b1) begin errors++; $display("FAIL pp_ack3: got int=%b empty=%b expected 1/1", i_s, e_s); end
    checks++;
  endtask

  task automatic test_flush();
    logic i_s, e_s;
    write_cycle(8'h31); write_cycle(8'h32); write_cycle(8'h33);
    apu_resb = 1'b0;
    tick();
    apu_resb = 1'b1;
    if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL flush_flags: got empty=%b full=%b expected 1/0", empty, full); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL flush_ovf: got %b expected 0", ovf); end
    checks++;
    if (apu_db !== 8'h00) begin errors++; $display("FAIL flush_db: got %h expected 00", apu_db); end
    checks++;
    scpub = 1'b0; wrb = 1'b0; db_i = 8'h44; cp2_negedge = 1'b1;
    tick();
    if (apu_db !== 8'h00) begin errors++; $display("FAIL flush_idle_early: got %h expected 00", apu_db); end
    checks++;
    cp2_negedge = 1'b0; scpub = 1'b1; wrb = 1'b1;
    tick();
    if (apu_db !== 8'h44) begin errors++; $display("FAIL flush_idle_db: got %h expected 44", apu_db); end
    checks++;
    strobe(1'b1, 1'b1, 8'h00);
    ack_pulse(i_s, e_s);
    apu_resb = 1'b0;
    strobe(1'b0, 1'b0, 8'h99);
    strobe(1'b1, 1'b1, 8'h00);
    apu_resb = 1'b1;
    tick();
    tick();
    if (empty !== 1'b1 || apu_db !== 8'h00) begin errors++; $display("FAIL flush_ignore: got empty=%b db=%h expected 1/00", empty, apu_db); end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic i_s, e_s;
    write_cycle(8'h55); write_cycle(8'h66);
    #2 rst = 1'b1;
    #1;
    if (empty !== 1'b1 || apu_db !== 8'h00) begin errors++; $display("FAIL rstmid_async: got empty=%b db=%h expected 1/00", empty, apu_db); end
    checks++;
    tick();
    rst = 1'b0;
    tick();
    write_cycle(8'h77);
    if (apu_db !== 8'h77) begin errors++; $display("FAIL rstmid_head: got %h expected 77", apu_db); end
    checks++;
    ack_pulse(i_s, e_s);
    if (e_s !== 1'b1) begin errors++; $display("FAIL rstmid_single: empty got %b expected 1", e_s); end
    checks++;
  endtask

`else

  task automatic test_passthrough();
    scpub = 1'b0; wrb = 1'b0; db_i = 8'hA5; cp2_negedge = 1'b1;
    #1;
    if (apu_db !== 8'h00) begin errors++; $display("FAIL pt_before_edge: got %h expected 00", apu_db); end
    checks++;
    tick();
    if (apu_db !== 8'hA5) begin errors++; $display("FAIL pt_one_clk: got %h expected a5", apu_db); end
    checks++;
    cp2_negedge = 1'b0; scpub = 1'b1; wrb = 1'b1;
    tick();
  endtask

  task automatic test_every_strobe();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    scpub = 1'b0; wrb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      db_i = vals[k]; cp2_negedge = 1'b1;
      tick();
      if (apu_db !== vals[k]) begin errors++; $display("FAIL strobe_%0d: got %h expected %h", k, apu_db, vals[k]); end
      checks++;
      cp2_negedge = 1'b0;
      tick();
    end
  endtask

  task automatic test_no_select();
    db_i = 8'h77;
    scpub = 1'b1; wrb = 1'b0; cp2_negedge = 1'b1;
    tick();
    if (apu_db !== 8'h33) begin errors++; $display("FAIL nosel_scpub: got %h expected 33", apu_db); end
    checks++;
    scpub = 1'b0; wrb = 1'b1;
    tick();
    if (apu_db !== 8'h33) begin errors++; $display("FAIL nosel_wrb: got %h expected 33", apu_db); end
    checks++;
    wrb = 1'b0; cp2_negedge = 1'b0;
    tick();
    if (apu_db !== 8'h33) begin errors++; $display("FAIL nosel_cp2: got %h expected 33", apu_db); end
    checks++;
    scpub = 1'b1; wrb = 1'b1;
  endtask

  task automatic test_ack();
    apu_ack = 1'b1;
    #1;
    if (cpu_int !== 1'b1) begin errors++; $display("FAIL ack_int_hi: got %b expected 1", cpu_int); end
    checks++;
    if (full !== 1'b0 || empty !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL ack_flags: got full=%b empty=%b ovf=%b expected 0/1/0", full, empty, ovf);
    end
    checks++;
    apu_ack = 1'b0;
    #1;
    if (cpu_int !== 1'b0) begin errors++; $display("FAIL ack_int_lo: got %b expected 0", cpu_int); end
    checks++;
    tick();
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    if (apu_db !== 8'h00) begin errors++; $display("FAIL async_rst_db: got %h expected 00", apu_db); end
    checks++;
    tick();
    rst = 1'b0;
    tick();
  endtask

`endif

  initial begin
    test_reset();
`ifdef APU_CMD_FIFO_EN
    test_single_write();
    test_wrb_held();
    test_overflow();
    test_push_pop();
    test_flush();
    test_reset_mid();
`else
    test_passthrough();
    test_every_strobe();
    test_no_select();
    test_ack();
    test_async_reset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apu_cmd_sched.md
APU_CMD_SCHED -- requirements
Module: apu_cmd_sched

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 CLK  in  1  system clock (2 x video XTAL); all state on posedge CLK.
REQ-003 RESET  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 CP2_NEGEDGE  in  1  CPU phase-2 falling-edge strobe, one CLK wide.
REQ-005 SCPUB  in  1  VDC sub-CPU (APU) select, active-low.
REQ-006 WRB  in  1  CPU write strobe, active-low.
REQ-007 DB_I  in  8  CPU data bus.
REQ-008 APU_RESB  in  1  APU reset from PC[3], active-low.
REQ-009 APU_ACK  in  1  APU handshake, PB[0].
REQ-010 APU_DB  out  8  byte presented on APU port A.
REQ-011 CPU_INT  out  1  level to CPU INT1.
REQ-012 FULL  out  1  FIFO full.
REQ-013 EMPTY  out  1  FIFO empty.
REQ-014 OVF  out  1  sticky overflow flag.

Function
REQ-015 Write event SHALL be CP2_NEGEDGE & ~SCPUB & ~WRB with wr_armed=1; wr_armed clears on event, sets when WRB=1 or SCPUB=1 is sampled on a CP2_NEGEDGE: exactly one push per CPU write cycle.
REQ-016 Write event with FIFO not full SHALL push DB_I; count +1 next CLK.
REQ-017 Write event with FIFO full SHALL drop the byte, leave FIFO unchanged, set OVF.
REQ-018 FSM states IDLE, PRESENT, RETIRE; reset state IDLE.
REQ-019 IDLE: EMPTY=0 -> PRESENT; APU_DB drives head entry from PRESENT entry onward.
REQ-020 PRESENT: APU_ACK rising edge (registered prev vs current) -> RETIRE and pop head same CLK.
REQ-021 RETIRE: APU_ACK=0 -> PRESENT if count>0 after pop, else IDLE; APU_DB holds popped byte until next PRESENT.
REQ-022 In IDLE APU_DB SHALL hold last presented byte (0x00 after reset).
REQ-023 Simultaneous push and pop SHALL leave count unchanged; pushed byte enters tail, FULL not asserted transiently.
REQ-024 Push into empty FIFO while in IDLE: byte on APU_DB exactly 2 CLK after the write event.
REQ-025 Pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits, 0..DEPTH.
REQ-026 FULL=(count==DEPTH), EMPTY=(count==0), both registered-consistent with count.
REQ-027 CPU_INT SHALL equal APU_ACK & EMPTY (CPU sees ack only for final queued byte).
REQ-028 APU_RESB=0 SHALL flush: count=0, pointers=0, OVF=0, state IDLE, APU_DB=0x00, writes ignored while low.
REQ-029 APU_ACK rising edge in IDLE or RETIRE SHALL be ignored.

Reset
REQ-030 RESET=1 SHALL asynchronously force: state IDLE, count 0, pointers 0, wr_armed 1, ack_prev 0, APU_DB 0x00, OVF 0, FULL 0, EMPTY 1, CPU_INT 0 (combinational from APU_ACK&EMPTY).
REQ-031 RESET mid-PRESENT SHALL discard all queued bytes; no pop recorded.

Configuration
REQ-032 Macro APU_CMD_FIFO_EN defined: FIFO and FSM per REQ-015..REQ-029.
REQ-033 Macro undefined: no FIFO/FSM; write event loads APU_DB directly (1 CLK latency), every CP2_NEGEDGE write latches (no wr_armed); FULL=0, EMPTY=1, OVF=0, CPU_INT=APU_ACK.

Verification
REQ-034 Write 0x5A to APU, idle FSM -> APU_DB=0x5A 2 CLK later, EMPTY=0, CPU_INT=0.
REQ-035 WRB held low across 3 CP2_NEGEDGE strobes with 0x11 -> one entry only, count=1.
REQ-036 Write 0x01..0x05 with DEPTH=4, no ack -> FULL=1 after 4th, 5th dropped, OVF=1; acks then yield 0x01..0x04 in order.
REQ-037 Push coincident with ack rising edge at count=2 -> count stays 2, order preserved; CPU_INT=1 only on ack of last byte.
REQ-038 APU_RESB low for 1 CLK with 3 queued -> EMPTY=1, OVF=0, APU_DB=0x00, state IDLE.
REQ-039 APU_CMD_FIFO_EN undefined: write 0xA5 -> APU_DB=0xA5 next CLK; APU_ACK=1 -> CPU_INT=1.
